// File: rtl/aia_src_gateway.sv
// Per-source interrupt gateway. Each source's sourcecfg mode picks how the
// already-synchronized wire is rectified: edge or level, either polarity,
// detached (software only) or inactive. The gateway then maintains one
// pending bit per source. Software writes and the claim handshake from the
// delivery logic clear the pending bits.
module aia_src_gateway #(
  parameter int NrSrc = 32,
  parameter int IdxW  = $clog2(NrSrc)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NrSrc-1:0]       i_src,
  input  logic [NrSrc-1:0][2:0]  i_mode,
  input  logic                   i_sw_valid,
  input  logic                   i_sw_set,
  input  logic [IdxW-1:0]        i_sw_idx,
  input  logic                   i_claim_valid,
  input  logic [IdxW-1:0]        i_claim_idx,
  output logic                   o_claim_ack,
  output logic [NrSrc-1:0]       o_rect,
  output logic [NrSrc-1:0]       o_pending
);

  localparam logic [2:0] ModeDetached = 3'd1;

  logic [NrSrc-1:0]      pend_q;
  logic [NrSrc-1:0]      prev_q;
  logic [NrSrc-1:0][2:0] mode_q;
  logic                  ack_q;

  logic [NrSrc-1:0] rect;
  logic [NrSrc-1:0] is_det;
  logic [NrSrc-1:0] is_edge;
  logic [NrSrc-1:0] is_level;
  logic [NrSrc-1:0] is_inact;
  logic [NrSrc-1:0] mode_chg;
  logic [NrSrc-1:0] sw_hit;
  logic [NrSrc-1:0] claim_clr;
  logic [NrSrc-1:0] hw_set;
  logic [NrSrc-1:0] sw_set;
  logic [NrSrc-1:0] sw_clr;
  logic [NrSrc-1:0] pend_d;
  logic             ack_d;

  // Modes 4..7 carry the wire; bit 0 of the mode selects inverted polarity.
  function automatic logic rectify(input logic src, input logic [2:0] mode);
    return mode[2] & (src ^ mode[0]);
  endfunction

  // Per-source mode decode, event sources and next pending value.
  always_comb begin
    for (int i = 0; i < NrSrc; i++) begin
      is_det[i]    = (i_mode[i] == ModeDetached);
      is_edge[i]   = (i_mode[i][2:1] == 2'b10);
      is_level[i]  = (i_mode[i][2:1] == 2'b11);
      // Reserved encodings 2 and 3 behave as inactive.
      is_inact[i]  = ~i_mode[i][2] & ~is_det[i];
      rect[i]      = rectify(i_src[i], i_mode[i]);
      mode_chg[i]  = (i_mode[i] != mode_q[i]);
      // Out-of-range indices never match any source, so they are dropped.
      sw_hit[i]    = i_sw_valid & (i_sw_idx == IdxW'(i));
      claim_clr[i] = i_claim_valid & (i_claim_idx == IdxW'(i));
      // A level source is held off for the claim cycle so the claim is
      // visible; the bit comes back next cycle if the level is still asserted.
      hw_set[i]    = (is_edge[i] & rect[i] & ~prev_q[i] & ~mode_chg[i])
                   | (is_level[i] & rect[i] & ~claim_clr[i]);
      sw_set[i]    = sw_hit[i] & i_sw_set & (is_det[i] | is_edge[i]);
      sw_clr[i]    = sw_hit[i] & ~i_sw_set & (is_det[i] | is_edge[i]);
      if (is_inact[i] | mode_chg[i]) begin
        pend_d[i] = 1'b0;
      end else begin
        pend_d[i] = (pend_q[i] & ~sw_clr[i] & ~claim_clr[i]) | hw_set[i] | sw_set[i];
      end
    end
    ack_d = |(claim_clr & pend_q);
  end

  // Gateway state: pending bits, last rectified input, last mode and claim ack.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pend_q <= '0;
      prev_q <= '0;
      mode_q <= '0;
      ack_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      prev_q <= rect;
      mode_q <= i_mode;
      ack_q  <= ack_d;
    end
  end

  assign o_rect      = rect;
  assign o_pending   = pend_q;
  assign o_claim_ack = ack_q;

endmodule

// File: tb/tb_aia_src_gateway.sv
// Bench for aia_src_gateway: directed scenarios followed by random traffic,
// every cycle checked against a per-source behavioural model.
module tb_aia_src_gateway;

  localparam int N  = 20;
  localparam int IW = $clog2(N);

  logic                i_clk = 1'b0;
  logic                i_rst;
  logic [N-1:0]        i_src;
  logic [N-1:0][2:0]   i_mode;
  logic                i_sw_valid;
  logic                i_sw_set;
  logic [IW-1:0]       i_sw_idx;
  logic                i_claim_valid;
  logic [IW-1:0]       i_claim_idx;
  logic                o_claim_ack;
  logic [N-1:0]        o_rect;
  logic [N-1:0]        o_pending;

  int ncmp  = 0;
  int nfail = 0;

  bit       m_pend[N];
  bit       m_prev[N];
  bit [2:0] m_mode[N];
  bit       m_ack;

  aia_src_gateway #(.NrSrc(N)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_src(i_src), .i_mode(i_mode),
    .i_sw_valid(i_sw_valid), .i_sw_set(i_sw_set), .i_sw_idx(i_sw_idx),
    .i_claim_valid(i_claim_valid), .i_claim_idx(i_claim_idx),
    .o_claim_ack(o_claim_ack), .o_rect(o_rect), .o_pending(o_pending)
  );

  always #5 i_clk = ~i_clk;

  function automatic bit rect_of(input bit s, input bit [2:0] m);
    case (m)
      3'd4, 3'd6: return s;
      3'd5, 3'd7: return !s;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [N-1:0] model_pend();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic logic [N-1:0] model_rect();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = rect_of(i_src[i], i_mode[i]);
    return v;
  endfunction

  task automatic check_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock from the current inputs, step the DUT,
  // and compare everything observable.
  task automatic tick();
    bit       np[N];
    bit       nack;
    bit [2:0] md;
    bit       r, set, clr, edge_m, level_m, det_m, claim_me, sw_me;
    #1;
    check_vec("rect", o_rect, model_rect());
    nack = 1'b0;
    if (i_rst) begin
      for (int i = 0; i < N; i++) begin
        np[i] = 1'b0; m_prev[i] = 1'b0; m_mode[i] = 3'd0;
      end
    end else begin
      if (i_claim_valid && int'(i_claim_idx) < N) nack = m_pend[i_claim_idx];
      for (int i = 0; i < N; i++) begin
        md       = i_mode[i];
        r        = rect_of(i_src[i], md);
        edge_m   = (md == 3'd4) || (md == 3'd5);
        level_m  = (md == 3'd6) || (md == 3'd7);
        det_m    = (md == 3'd1);
        claim_me = i_claim_valid && (int'(i_claim_idx) == i);
        sw_me    = i_sw_valid && (int'(i_sw_idx) == i);
        set = 1'b0;
        clr = claim_me;
        if (md != m_mode[i] || !(edge_m || level_m || det_m)) begin
          np[i] = 1'b0;
        end else begin
          if (edge_m && r && !m_prev[i]) set = 1'b1;
          if (level_m && r && !claim_me) set = 1'b1;
          if (sw_me && (det_m || edge_m)) begin
            if (i_sw_set) set = 1'b1;
            else          clr = 1'b1;
          end
          np[i] = set ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
        end
        m_prev[i] = r;
        m_mode[i] = md;
      end
    end
    m_pend = np;
    m_ack  = nack;
    @(posedge i_clk);
    #1;
    check_vec("pending", o_pending, model_pend());
    check_bit("claim_ack", o_claim_ack, m_ack);
  endtask

  task automatic idle();
    i_sw_valid    = 1'b0;
    i_claim_valid = 1'b0;
  endtask

  task automatic claim(input int idx);
    i_claim_valid = 1'b1;
    i_claim_idx   = IW'(idx);
  endtask

  task automatic sw(input int idx, input bit set);
    i_sw_valid = 1'b1;
    i_sw_set   = set;
    i_sw_idx   = IW'(idx);
  endtask

  initial begin
    i_rst = 1'b1; i_src = '0; i_mode = '0;
    i_sw_valid = 1'b0; i_sw_set = 1'b0; i_sw_idx = '0;
    i_claim_valid = 1'b0; i_claim_idx = '0;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0; m_prev[i] = 1'b0; m_mode[i] = 3'd0;
    end
    m_ack = 1'b0;
    @(negedge i_clk);
    tick(); tick();
    check_vec("reset_pending", o_pending, '0);
    check_bit("reset_ack", o_claim_ack, 1'b0);

    // Configure sources and let the mode change settle.
    i_rst = 1'b0;
    i_mode[1] = 3'd4; i_mode[3] = 3'd4; i_mode[5] = 3'd5;
    i_mode[7] = 3'd6; i_mode[2] = 3'd1; i_mode[4] = 3'd0;
    i_src[5] = 1'b1;
    tick(); tick();

    // Rising edge on an EDGE1 source, held high across a claim.
    i_src[3] = 1'b1; tick();
    check_bit("edge1_set", o_pending[3], 1'b1);
    repeat (3) tick();
    claim(3); tick(); idle();
    check_bit("edge1_claim_ack", o_claim_ack, 1'b1);
    check_bit("edge1_claim_clr", o_pending[3], 1'b0);
    repeat (7) tick();
    check_bit("edge1_held_no_reset", o_pending[3], 1'b0);

    // EDGE0: falling edge sets, rising edge does nothing.
    i_src[5] = 1'b0; tick();
    check_bit("edge0_set", o_pending[5], 1'b1);
    i_src[5] = 1'b1; tick();
    check_bit("edge0_rise_noop", o_pending[5], 1'b1);

    // LEVEL1: claim drops pending for one cycle, then it returns.
    i_src[7] = 1'b1; tick();
    check_bit("level_set", o_pending[7], 1'b1);
    claim(7); tick(); idle();
    check_bit("level_claim_ack", o_claim_ack, 1'b1);
    check_bit("level_claim_gap", o_pending[7], 1'b0);
    tick();
    check_bit("level_reassert", o_pending[7], 1'b1);
    i_src[7] = 1'b0; claim(7); tick(); idle();
    check_bit("level_low_claim", o_pending[7], 1'b0);
    sw(7, 1'b1); tick(); idle();
    check_bit("level_sw_ignored", o_pending[7], 1'b0);

    // DETACHED: wire ignored, software controls pending.
    for (int k = 0; k < 4; k++) begin
      i_src[2] = ~i_src[2]; tick();
    end
    check_bit("det_wire_ignored", o_pending[2], 1'b0);
    sw(2, 1'b1); tick(); idle();
    check_bit("det_sw_set", o_pending[2], 1'b1);
    sw(2, 1'b0); tick(); idle();
    check_bit("det_sw_clr", o_pending[2], 1'b0);

    // Edge arriving together with a claim of the same source.
    i_src[1] = 1'b1; claim(1); tick(); idle();
    check_bit("edge_vs_claim", o_pending[1], 1'b1);
    check_bit("edge_vs_claim_ack", o_claim_ack, 1'b0);

    // INACTIVE -> EDGE1 with the wire already high: no pending.
    i_src[4] = 1'b1; tick();
    i_mode[4] = 3'd4; tick();
    check_bit("modechg_clear", o_pending[4], 1'b0);
    tick();
    check_bit("modechg_no_edge", o_pending[4], 1'b0);

    // Out-of-range indices are dropped.
    sw(25, 1'b1); claim(25); tick(); idle();
    check_bit("oor_claim_ack", o_claim_ack, 1'b0);

    // Claim and software set on the same source in the same cycle.
    claim(3); sw(3, 1'b1); tick(); idle();
    check_bit("claim_and_swset", o_pending[3], 1'b1);

    // Reset mid-run drops all pending state.
    sw(2, 1'b1); tick(); idle();
    i_rst = 1'b1; claim(1); tick(); idle();
    check_vec("midrun_reset_pending", o_pending, '0);
    check_bit("midrun_reset_ack", o_claim_ack, 1'b0);
    i_rst = 1'b0;
    tick();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      i_src = N'($urandom);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 15) == 0) i_mode[i] = 3'($urandom_range(0, 7));
      i_sw_valid    = ($urandom_range(0, 2) == 0);
      i_sw_set      = 1'($urandom);
      i_sw_idx      = IW'($urandom_range(0, 31));
      i_claim_valid = ($urandom_range(0, 1) == 0);
      i_claim_idx   = IW'($urandom_range(0, 31));
      i_rst         = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
